decode_latch: RTL
=================

DECODE_LATCH -- requirements
Module: decode_latch

Interface
REQ-001 The block SHALL run on one clock and an asynchronous, active-low reset, with ports named CLK and nRST.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold all registered state this edge.
REQ-005 flush  input  1  replace the latched entry with a bubble this edge.
REQ-006 valid_in  input  1  decode stage presents a real instruction.
REQ-007 instr_in, pc_in  input  32 each  instruction word and its PC, from decode.
REQ-008 rdat1_in, rdat2_in, extOut_in  input  32 each  register operands and extended immediate.
REQ-009 wsel_in  input  5  destination register.
REQ-010 ALUOp_in  input  4  ALU operation; PCSrc_in  input  2  next-PC select.
REQ-011 RegWr_in, MemToReg_in, WrLinkReg_in, MemRd_in, MemWr_in, ALUSrc_in, halt_in  input  1 each  control bits.
REQ-012 The block SHALL provide an output named <x>_out, of matching width, for every <x>_in in REQ-006..REQ-011 (valid_in maps to valid_out).
REQ-013 hazard  output  1  load-use hazard against the instruction currently in decode.
REQ-014 bubbles  output  32  bubble-cycle count; present only with DECODE_LATCH_PERF_EN.

Function
REQ-015 All *_out registers SHALL update only on the rising CLK edge, one cycle after their inputs.
REQ-016 Priority SHALL be: reset > flush > halt-hold > stall > load.
REQ-017 On flush, every *_out register, including valid_out, pc_out and instr_out, SHALL become 0.
REQ-018 If flush and stall are asserted together, flush SHALL win.
REQ-019 When stall=1 and flush=0, every *_out register SHALL hold its value.
REQ-020 On load (stall=0, flush=0, no halt-hold), every *_out SHALL take its *_in value.
REQ-021 When valid_in=0 on a load, RegWr_out, MemRd_out, MemWr_out and halt_out SHALL be forced to 0; the other fields load as normal.
REQ-022 Halt-hold: once valid_out=1 and halt_out=1, the block SHALL ignore loads and hold until flush or reset.
REQ-023 hazard SHALL be combinational and equal valid_out & MemRd_out & RegWr_out & (wsel_out!=0) & ((wsel_out==instr_in[25:21]) | (wsel_out==instr_in[20:16])).
REQ-024 hazard SHALL be 0 while halt-hold is active.
REQ-025 A register write to $0 (wsel_out=0) SHALL never raise hazard.

Reset
REQ-026 While nRST=0, all outputs SHALL be 0 immediately, without waiting for CLK.
REQ-027 Reset asserted mid-stall or mid-halt-hold SHALL clear the entire state.
REQ-028 After nRST rises, the first CLK edge SHALL behave as a normal load.

Configuration
REQ-029 With DECODE_LATCH_PERF_EN defined, the block SHALL provide bubbles.
REQ-030 bubbles SHALL increment on every CLK edge where valid_out=0 after that edge, counting both flush and invalid loads.
REQ-031 bubbles SHALL saturate at 32'hFFFFFFFF and reset to 0.
REQ-032 Without DECODE_LATCH_PERF_EN, the block SHALL have neither the bubbles port nor the counter logic, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset then load: drive valid_in=1, pc_in=0x40, RegWr_in=1, wsel_in=5, then one edge -> pc_out=0x40, wsel_out=5, RegWr_out=1, valid_out=1.
REQ-034 Stall hold: with pc_out=0x40 latched, set stall=1 and pc_in=0x44 for 3 edges -> pc_out stays 0x40; release stall -> pc_out=0x44 next edge.
REQ-035 Flush vs stall: with flush=1 and stall=1 on one edge -> all outputs 0, valid_out=0; under PERF_EN, bubbles increments by 1.
REQ-036 Load-use: latch lw with MemRd=1, RegWr=1, wsel=8, then drive instr_in with rs=8 -> hazard=1; with rs=rt=9 -> hazard=0; with wsel=0 -> hazard=0.
REQ-037 Halt: latch halt_in=1 with valid_in=1, then load new values for 4 edges -> outputs unchanged; flush -> all 0.
REQ-038 Async reset: pulse nRST low between clock edges during stall -> outputs 0 before the next edge; under PERF_EN, force bubbles to the saturation value, then 2 bubble edges -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/decode_latch.sv
// Decode/execute pipeline latch with flush, stall, halt-hold and load-use hazard detection.
// Optional bubble counter is enabled by defining DECODE_LATCH_PERF_EN.
module decode_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rdat1_in,
  input  logic [31:0] rdat2_in,
  input  logic [31:0] extOut_in,
  input  logic [4:0]  wsel_in,
  input  logic [3:0]  ALUOp_in,
  input  logic [1:0]  PCSrc_in,
  input  logic        RegWr_in,
  input  logic        MemToReg_in,
  input  logic        WrLinkReg_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        ALUSrc_in,
  input  logic        halt_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] rdat1_out,
  output logic [31:0] rdat2_out,
  output logic [31:0] extOut_out,
  output logic [4:0]  wsel_out,
  output logic [3:0]  ALUOp_out,
  output logic [1:0]  PCSrc_out,
  output logic        RegWr_out,
  output logic        MemToReg_out,
  output logic        WrLinkReg_out,
  output logic        MemRd_out,
  output logic        MemWr_out,
  output logic        ALUSrc_out,
  output logic        halt_out,
  output logic        hazard
`ifdef DECODE_LATCH_PERF_EN
  ,
  output logic [31:0] bubbles
`endif
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_rdat1;
  logic [31:0] r_rdat2;
  logic [31:0] r_ext;
  logic [4:0]  r_wsel;
  logic [3:0]  r_aluop;
  logic [1:0]  r_pcsrc;
  logic        r_regwr;
  logic        r_memtoreg;
  logic        r_wrlink;
  logic        r_memrd;
  logic        r_memwr;
  logic        r_alusrc;
  logic        r_halt;

  logic        w_n_valid;
  logic [31:0] w_n_instr;
  logic [31:0] w_n_pc;
  logic [31:0] w_n_rdat1;
  logic [31:0] w_n_rdat2;
  logic [31:0] w_n_ext;
  logic [4:0]  w_n_wsel;
  logic [3:0]  w_n_aluop;
  logic [1:0]  w_n_pcsrc;
  logic        w_n_regwr;
  logic        w_n_memtoreg;
  logic        w_n_wrlink;
  logic        w_n_memrd;
  logic        w_n_memwr;
  logic        w_n_alusrc;
  logic        w_n_halt;

  logic        w_halt_hold;
  logic        w_load;
  logic        w_rs_match;
  logic        w_rt_match;

  // A latched, valid halt freezes the stage until flush or reset.
  assign w_halt_hold = r_valid & r_halt;
  assign w_load      = ~w_halt_hold & ~stall;

  // Next entry: flush beats halt-hold, which beats stall, which beats load.
  always_comb begin
    w_n_valid    = r_valid;
    w_n_instr    = r_instr;
    w_n_pc       = r_pc;
    w_n_rdat1    = r_rdat1;
    w_n_rdat2    = r_rdat2;
    w_n_ext      = r_ext;
    w_n_wsel     = r_wsel;
    w_n_aluop    = r_aluop;
    w_n_pcsrc    = r_pcsrc;
    w_n_regwr    = r_regwr;
    w_n_memtoreg = r_memtoreg;
    w_n_wrlink   = r_wrlink;
    w_n_memrd    = r_memrd;
    w_n_memwr    = r_memwr;
    w_n_alusrc   = r_alusrc;
    w_n_halt     = r_halt;
    if (flush) begin
      w_n_valid    = 1'b0;
      w_n_instr    = 32'd0;
      w_n_pc       = 32'd0;
      w_n_rdat1    = 32'd0;
      w_n_rdat2    = 32'd0;
      w_n_ext      = 32'd0;
      w_n_wsel     = 5'd0;
      w_n_aluop    = 4'd0;
      w_n_pcsrc    = 2'd0;
      w_n_regwr    = 1'b0;
      w_n_memtoreg = 1'b0;
      w_n_wrlink   = 1'b0;
      w_n_memrd    = 1'b0;
      w_n_memwr    = 1'b0;
      w_n_alusrc   = 1'b0;
      w_n_halt     = 1'b0;
    end else if (w_load) begin
      // Side-effecting controls are squashed for a non-instruction slot.
      w_n_valid    = valid_in;
      w_n_instr    = instr_in;
      w_n_pc       = pc_in;
      w_n_rdat1    = rdat1_in;
      w_n_rdat2    = rdat2_in;
      w_n_ext      = extOut_in;
      w_n_wsel     = wsel_in;
      w_n_aluop    = ALUOp_in;
      w_n_pcsrc    = PCSrc_in;
      w_n_regwr    = RegWr_in & valid_in;
      w_n_memtoreg = MemToReg_in;
      w_n_wrlink   = WrLinkReg_in;
      w_n_memrd    = MemRd_in & valid_in;
      w_n_memwr    = MemWr_in & valid_in;
      w_n_alusrc   = ALUSrc_in;
      w_n_halt     = halt_in & valid_in;
    end else begin
      w_n_valid    = r_valid;
    end
  end

  // Latch register bank.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_pc       <= 32'd0;
      r_rdat1    <= 32'd0;
      r_rdat2    <= 32'd0;
      r_ext      <= 32'd0;
      r_wsel     <= 5'd0;
      r_aluop    <= 4'd0;
      r_pcsrc    <= 2'd0;
      r_regwr    <= 1'b0;
      r_memtoreg <= 1'b0;
      r_wrlink   <= 1'b0;
      r_memrd    <= 1'b0;
      r_memwr    <= 1'b0;
      r_alusrc   <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_valid    <= w_n_valid;
      r_instr    <= w_n_instr;
      r_pc       <= w_n_pc;
      r_rdat1    <= w_n_rdat1;
      r_rdat2    <= w_n_rdat2;
      r_ext      <= w_n_ext;
      r_wsel     <= w_n_wsel;
      r_aluop    <= w_n_aluop;
      r_pcsrc    <= w_n_pcsrc;
      r_regwr    <= w_n_regwr;
      r_memtoreg <= w_n_memtoreg;
      r_wrlink   <= w_n_wrlink;
      r_memrd    <= w_n_memrd;
      r_memwr    <= w_n_memwr;
      r_alusrc   <= w_n_alusrc;
      r_halt     <= w_n_halt;
    end
  end

  // Load-use: the latched load targets a source of the instruction now in decode.
  assign w_rs_match = (r_wsel == instr_in[25:21]);
  assign w_rt_match = (r_wsel == instr_in[20:16]);
  assign hazard     = ~w_halt_hold & r_valid & r_memrd & r_regwr &
                      (r_wsel != 5'd0) & (w_rs_match | w_rt_match);

  assign valid_out     = r_valid;
  assign instr_out     = r_instr;
  assign pc_out        = r_pc;
  assign rdat1_out     = r_rdat1;
  assign rdat2_out     = r_rdat2;
  assign extOut_out    = r_ext;
  assign wsel_out      = r_wsel;
  assign ALUOp_out     = r_aluop;
  assign PCSrc_out     = r_pcsrc;
  assign RegWr_out     = r_regwr;
  assign MemToReg_out  = r_memtoreg;
  assign WrLinkReg_out = r_wrlink;
  assign MemRd_out     = r_memrd;
  assign MemWr_out     = r_memwr;
  assign ALUSrc_out    = r_alusrc;
  assign halt_out      = r_halt;

`ifdef DECODE_LATCH_PERF_EN
  logic [31:0] r_bubbles;

  // Saturating count of edges that leave an empty slot in the latch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bubbles <= 32'd0;
    end else if (!w_n_valid && (r_bubbles != 32'hFFFF_FFFF)) begin
      r_bubbles <= r_bubbles + 32'd1;
    end else begin
      r_bubbles <= r_bubbles;
    end
  end

  assign bubbles = r_bubbles;
`endif

endmodule
